// File: rtl/e_traceback_213_pkg.sv
// Shared constants, FSM encoding and the trellis predecessor step
// for the (2,1,3) Viterbi traceback block.
package e_traceback_213_pkg;

  localparam int M     = 3;
  localparam int NS    = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LW    = AW + 1;

  typedef enum logic [1:0] {
    TB_FILL  = 2'd0,
    TB_TRACE = 2'd1,
    TB_EMIT  = 2'd2
  } tb_fsm_e;

  // Predecessor of state s: shift in the stored survivor bit as the new LSB.
  function automatic logic [M-1:0] tb_pred(input logic [M-1:0] s, input logic [NS-1:0] dv);
    return {s[M-2:0], dv[s]};
  endfunction

endpackage

// File: rtl/e_survivor_mem_213.sv
// Survivor-decision storage: DEPTH rows of NS decision bits,
// synchronous write, combinational read.
module e_survivor_mem_213
  import e_traceback_213_pkg::*;
(
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [NS-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [NS-1:0] rd_data
);

  logic [NS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/e_traceback_213.sv
// Frame-based traceback: fills survivor memory, traces back from min_state,
// then emits decoded bits in time order over a valid/ready handshake.
module e_traceback_213
  import e_traceback_213_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec_valid,
  output logic          dec_ready,
  input  logic [NS-1:0] dec_vec,
  input  logic          frame_last,
  input  logic [M-1:0]  min_state,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic          frame_err
);

  tb_fsm_e        state, state_nxt;
  logic [AW-1:0]  wr_ptr, rd_ptr, idx;
  logic [LW-1:0]  len;
  logic [M-1:0]   tb_state;
  logic [DEPTH-1:0] bit_buf;
  logic [NS-1:0]  rd_vec;
  logic           accept, at_top, frame_end, emit_fire, emit_last;

  assign dec_ready = (state == TB_FILL);
  assign out_valid = (state == TB_EMIT);
  assign accept    = dec_valid && dec_ready;
  assign at_top    = (wr_ptr == AW'(DEPTH - 1));
  assign frame_end = accept && (frame_last || at_top);
  assign emit_last = ({1'b0, idx} == (len - LW'(1)));
  assign emit_fire = out_valid && out_ready;

  // Gated by EMIT so both outputs read zero outside the emit phase.
  assign out_bit  = out_valid && bit_buf[idx];
  assign out_last = out_valid && emit_last;

  e_survivor_mem_213 u_mem (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (dec_vec),
    .rd_addr (rd_ptr),
    .rd_data (rd_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TB_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TB_FILL:  if (frame_end) state_nxt = TB_TRACE;
      TB_TRACE: if (rd_ptr == '0) state_nxt = TB_EMIT;
      TB_EMIT:  if (emit_fire && emit_last) state_nxt = TB_FILL;
      default:  state_nxt = TB_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idx       <= '0;
      len       <= '0;
      tb_state  <= '0;
      frame_err <= 1'b0;
    end else begin
      // A forced end is an accept on the last row without frame_last.
      frame_err <= accept && at_top && !frame_last;
      case (state)
        TB_FILL: begin
          if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (frame_end) begin
              len      <= LW'(wr_ptr) + LW'(1);
              tb_state <= min_state;
              rd_ptr   <= wr_ptr;
              idx      <= '0;
            end
          end
        end
        TB_TRACE: begin
          tb_state <= tb_pred(tb_state, rd_vec);
          rd_ptr   <= rd_ptr - AW'(1);
        end
        TB_EMIT: begin
          if (emit_fire) begin
            idx <= idx + AW'(1);
            if (emit_last) wr_ptr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded bits land in time order, so EMIT reads them forward by idx.
  always_ff @(posedge clk) begin
    if (state == TB_TRACE) bit_buf[rd_ptr] <= tb_state[M-1];
  end

endmodule
